// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single registered read port of the background VRAM
// between the VGA display fetch (fully pipelined, absolute priority) and the
// auxiliary game-logic requester (one outstanding request, valid/ready).
// Optional build macro VRAM_ARB_FAIR_EN: a starved aux request is forced onto
// the VRAM port, dropping that cycle's display read and flagging disp_miss.
module vram_arbiter #(
  parameter int DATA_WIDTH   = 13,
  parameter int ADDR_WIDTH   = 15,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_valid,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_miss,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  output logic                  aux_rvalid,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic                  aux_starved,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  input  logic [DATA_WIDTH-1:0] vram_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         wait_cnt, wait_cnt_nx;
  logic [ADDR_WIDTH-1:0] aux_addr_q;
  logic                  disp_tag;
  logic                  aux_issue;
  logic                  at_limit;
  logic                  force_issue;

  assign at_limit = (wait_cnt == CW'(STARVE_LIMIT));

`ifdef VRAM_ARB_FAIR_EN
  assign force_issue = at_limit;
`else
  assign force_issue = 1'b0;
`endif

  // Aux FSM: next state, wait counter, handshake and starvation flag
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    aux_issue   = 1'b0;
    aux_ready   = 1'b0;
    aux_starved = 1'b0;
    case (state)
      IDLE: begin
        aux_ready = 1'b1;
        if (aux_valid) begin
          state_nx    = PEND;
          wait_cnt_nx = '0;
        end
      end
      PEND: begin
        aux_starved = at_limit;
        if (!disp_req || force_issue) begin
          aux_issue = 1'b1;
          state_nx  = WAIT;
        end else if (!at_limit) begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      WAIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // VRAM address mux: aux only in its issue cycle, display otherwise
  always_comb begin
    vram_addr = disp_addr;
    if (aux_issue) vram_addr = aux_addr_q;
  end

  // Aux FSM state, wait counter and captured request address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      aux_addr_q <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (state == IDLE && aux_valid) aux_addr_q <= aux_addr;
    end
  end

  // Display pipeline: issue tag, then capture VRAM word one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_tag   <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      disp_tag   <= disp_req && !aux_issue;
      disp_valid <= disp_tag;
      if (disp_tag) disp_data <= vram_data;
    end
  end

  // Aux return: the WAIT state is the aux in-flight tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aux_rvalid <= 1'b0;
      aux_rdata  <= '0;
    end else begin
      aux_rvalid <= (state == WAIT);
      if (state == WAIT) aux_rdata <= vram_data;
    end
  end

`ifdef VRAM_ARB_FAIR_EN
  logic miss_tag;

  // Dropped display read: tag follows the same 2-cycle alignment as disp_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_tag  <= 1'b0;
      disp_miss <= 1'b0;
    end else begin
      miss_tag  <= disp_req && aux_issue;
      disp_miss <= miss_tag;
    end
  end
`else
  assign disp_miss = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter. A timestamp-based reference model
// predicts, per cycle, the arbiter's combinational outputs and schedules the
// registered returns (display / aux / miss) two cycles ahead.
module tb_vram_arbiter;

  localparam int DW   = 13;
  localparam int AW   = 15;
  localparam int SL   = 64;
  localparam int MAXC = 1024;
`ifdef VRAM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          disp_miss;
  logic          aux_valid;
  logic          aux_ready;
  logic [AW-1:0] aux_addr;
  logic          aux_rvalid;
  logic [DW-1:0] aux_rdata;
  logic          aux_starved;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_data;

  vram_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_miss  (disp_miss),
    .aux_valid  (aux_valid),
    .aux_ready  (aux_ready),
    .aux_addr   (aux_addr),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata),
    .aux_starved(aux_starved),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM contents: low 13 address bits, top two address bits folded into the MSBs
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = a[DW-1:0];
    w[DW-1 -: 2] = w[DW-1 -: 2] ^ a[AW-1 -: 2];
    return w;
  endfunction

  // 1-cycle registered read VRAM
  always @(posedge clk) vram_data <= word_of(vram_addr);

  // Reference model state
  int            cyc;
  bit            pend;
  int            acc_cyc;
  int            waitn;
  int            ready_from;
  logic [AW-1:0] aq;
  logic [DW-1:0] rd_hold;
  bit            exp_dv [MAXC];
  logic [DW-1:0] exp_dd [MAXC];
  bit            exp_ms [MAXC];
  bit            exp_rv [MAXC];
  logic [DW-1:0] exp_rd [MAXC];

  int n_cmp, n_err;
  int seen_dv, seen_ms, seen_rv, seen_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend       = 1'b0;
    acc_cyc    = 0;
    waitn      = 0;
    ready_from = 0;
    aq         = '0;
    rd_hold    = '0;
    cyc        = 0;
    for (int i = 0; i < MAXC; i++) begin
      exp_dv[i] = 1'b0;
      exp_dd[i] = '0;
      exp_ms[i] = 1'b0;
      exp_rv[i] = 1'b0;
      exp_rd[i] = '0;
    end
  endtask

  // One clock cycle: drive inputs, predict, then check everything observable
  task automatic step(input bit dr, input logic [AW-1:0] da,
                      input bit av, input logic [AW-1:0] aa);
    bit            rdy, elig, starv, issue;
    logic [AW-1:0] ea;
    @(negedge clk);
    disp_req  = dr;
    disp_addr = da;
    aux_valid = av;
    aux_addr  = aa;

    rdy   = !pend && (cyc >= ready_from);
    elig  = pend && (cyc > acc_cyc);
    starv = elig && (waitn == SL);
    issue = elig && (!dr || (FAIR && waitn == SL));
    ea    = issue ? aq : da;
    if (issue) begin
      exp_rv[cyc+2] = 1'b1;
      exp_rd[cyc+2] = word_of(aq);
      ready_from    = cyc + 2;
      pend          = 1'b0;
    end else if (elig && waitn < SL) begin
      waitn++;
    end
    if (dr) begin
      if (issue) exp_ms[cyc+2] = 1'b1;
      else begin
        exp_dv[cyc+2] = 1'b1;
        exp_dd[cyc+2] = word_of(da);
      end
    end
    if (rdy && av) begin
      pend    = 1'b1;
      acc_cyc = cyc;
      waitn   = 0;
      aq      = aa;
    end
    if (exp_rv[cyc]) rd_hold = exp_rd[cyc];

    #1;
    chk("aux_ready", 32'(aux_ready), 32'(rdy));
    chk("aux_starved", 32'(aux_starved), 32'(starv));
    chk("vram_addr", 32'(vram_addr), 32'(ea));
    chk("disp_valid", 32'(disp_valid), 32'(exp_dv[cyc]));
    if (exp_dv[cyc]) chk("disp_data", 32'(disp_data), 32'(exp_dd[cyc]));
    chk("disp_miss", 32'(disp_miss), 32'(exp_ms[cyc]));
    chk("aux_rvalid", 32'(aux_rvalid), 32'(exp_rv[cyc]));
    chk("aux_rdata", 32'(aux_rdata), 32'(rd_hold));
    if (disp_valid === 1'b1)  seen_dv++;
    if (disp_miss === 1'b1)   seen_ms++;
    if (aux_rvalid === 1'b1)  seen_rv++;
    if (aux_starved === 1'b1) seen_st++;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
    chk({tag, "_disp_data"}, 32'(disp_data), 32'd0);
    chk({tag, "_disp_miss"}, 32'(disp_miss), 32'd0);
    chk({tag, "_aux_rvalid"}, 32'(aux_rvalid), 32'd0);
    chk({tag, "_aux_rdata"}, 32'(aux_rdata), 32'd0);
    chk({tag, "_aux_starved"}, 32'(aux_starved), 32'd0);
    chk({tag, "_aux_ready"}, 32'(aux_ready), 32'd1);
  endtask

  // Asynchronous reset asserted between edges; pending work must vanish
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst       = 1'b1;
    disp_req  = 1'b0;
    aux_valid = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    int            base_dv, base_ms, base_rv, base_st;
    logic [AW-1:0] top_addr;
    n_cmp = 0;
    n_err = 0;
    seen_dv = 0; seen_ms = 0; seen_rv = 0; seen_st = 0;
    rst       = 1'b1;
    disp_req  = 1'b0;
    disp_addr = '0;
    aux_valid = 1'b0;
    aux_addr  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Idle after reset
    repeat (3) step(1'b0, '0, 1'b0, '0);

    // Display burst, addresses 0..7
    base_dv = seen_dv;
    for (int i = 0; i < 8; i++) step(1'b1, AW'(i), 1'b0, '0);
    repeat (4) step(1'b0, '0, 1'b0, '0);
    chk("disp_burst_count", 32'(seen_dv - base_dv), 32'd8);

    // Single aux read of the highest address
    top_addr = '1;
    step(1'b0, '0, 1'b1, top_addr);
    repeat (4) step(1'b0, '0, 1'b0, '0);
    chk("aux_top_data", 32'(aux_rdata), 32'(word_of(top_addr)));

    // Aux request under 100 cycles of continuous display traffic
    base_ms = seen_ms;
    base_st = seen_st;
    base_rv = seen_rv;
    step(1'b1, rand_addr(), 1'b1, 15'h1234);
    for (int i = 1; i < 100; i++) step(1'b1, rand_addr(), 1'b0, rand_addr());
    repeat (6) step(1'b0, rand_addr(), 1'b0, '0);
    chk("starve_miss_count", 32'(seen_ms - base_ms), FAIR ? 32'd1 : 32'd0);
    chk("starve_flag_cycles", 32'(seen_st - base_st), FAIR ? 32'd1 : 32'd36);
    chk("starve_rvalid_count", 32'(seen_rv - base_rv), 32'd1);
    chk("starve_rdata", 32'(aux_rdata), 32'(word_of(15'h1234)));

    // Reset while an aux request is pending: it must never return
    step(1'b1, rand_addr(), 1'b1, rand_addr());
    repeat (4) step(1'b1, rand_addr(), 1'b0, '0);
    do_reset();
    base_rv = seen_rv;
    repeat (8) step(1'b0, rand_addr(), 1'b0, '0);
    chk("dropped_aux_rvalid", 32'(seen_rv - base_rv), 32'd0);

    // Alternating display slots with continuous aux demand
    base_ms = seen_ms;
    for (int i = 0; i < 40; i++) step((i % 2) == 0, rand_addr(), 1'b1, rand_addr());
    repeat (4) step(1'b0, '0, 1'b0, '0);
    chk("alt_no_miss", 32'(seen_ms - base_ms), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 1) == 1, rand_addr());
    repeat (4) step(1'b0, '0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
